// File: rtl/risc_pkg.sv
// ============================================================================
// risc_pkg : widths and loader state encoding shared by processor, memory, loader. rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package risc_pkg;

  localparam int RISC_DATA_W = 8;
  localparam int RISC_ADDR_W = 8;

  // A length byte of zero encodes a full page of 2**DATA_W payload bytes rather than an empty load.
  localparam bit LEN_ZERO_MEANS_256 = 1'b1;

  typedef enum logic [2:0] {
    LD_LEN  = 3'd0,
    LD_DATA = 3'd1,
    LD_CHK  = 3'd2,
    LD_RUN  = 3'd3,
    LD_ERR  = 3'd4
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_loader.sv
// ============================================================================
// mem_loader : streams a length/payload/XOR-checksum image into memory, then releases the CPU. rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_loader
  import risc_pkg::*;
#(
  parameter int                 DATA_W    = RISC_DATA_W,
  parameter int                 ADDR_W    = RISC_ADDR_W,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              load_req,
  output logic [DATA_W-1:0] Mem_IN,
  output logic [ADDR_W-1:0] Mem_ADDR,
  output logic              write,
  output logic              cpu_run,
  output logic              load_err,
  output logic [8:0]        bytes_loaded
);

  loader_state_t     state;
  logic [DATA_W:0]   remaining;
  logic [DATA_W-1:0] chk;
  logic [ADDR_W-1:0] addr;

  logic              xfer;
  logic [DATA_W:0]   len_count;

  assign xfer = in_valid && in_ready;

  // Length byte widened by one bit so that a full page fits in the down-counter.
  assign len_count = (in_data == '0 && LEN_ZERO_MEANS_256) ? (DATA_W+1)'(1 << DATA_W)
                                                           : {1'b0, in_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= LD_LEN;
      in_ready     <= 1'b0;
      write        <= 1'b0;
      Mem_IN       <= '0;
      Mem_ADDR     <= BASE_ADDR;
      addr         <= BASE_ADDR;
      cpu_run      <= 1'b0;
      load_err     <= 1'b0;
      bytes_loaded <= '0;
      remaining    <= '0;
      chk          <= '0;
    end else begin
      write <= 1'b0;
      case (state)
        LD_LEN: begin
          in_ready <= 1'b1;
          if (xfer) begin
            remaining    <= len_count;
            chk          <= in_data;
            addr         <= BASE_ADDR;
            bytes_loaded <= '0;
            state        <= (len_count == '0) ? LD_CHK : LD_DATA;
          end
        end

        LD_DATA: begin
          if (xfer) begin
            write        <= 1'b1;
            Mem_IN       <= in_data;
            Mem_ADDR     <= addr;
            addr         <= addr + ADDR_W'(1);
            chk          <= chk ^ in_data;
            bytes_loaded <= bytes_loaded + 9'd1;
            remaining    <= remaining - (DATA_W+1)'(1);
            if (remaining == (DATA_W+1)'(1)) begin
              state <= LD_CHK;
            end
          end
        end

        LD_CHK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_data == chk) begin
              state   <= LD_RUN;
              cpu_run <= 1'b1;
            end else begin
              state    <= LD_ERR;
              load_err <= 1'b1;
            end
          end
        end

        LD_RUN, LD_ERR: begin
          if (load_req) begin
            cpu_run  <= 1'b0;
            load_err <= 1'b0;
            in_ready <= 1'b1;
            state    <= LD_LEN;
          end
        end

        default: begin
          state    <= LD_LEN;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_loader.sv
// ============================================================================
// tb_mem_loader : directed streams with a write scoreboard checked by an independent monitor. rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_loader;
  import risc_pkg::*;

  localparam logic [7:0] BASE = 8'h80;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       load_req;
  logic [7:0] Mem_IN;
  logic [7:0] Mem_ADDR;
  logic       write;
  logic       cpu_run;
  logic       load_err;
  logic [8:0] bytes_loaded;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  mem_loader #(
    .DATA_W   (8),
    .ADDR_W   (8),
    .BASE_ADDR(BASE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .load_req    (load_req),
    .Mem_IN      (Mem_IN),
    .Mem_ADDR    (Mem_ADDR),
    .write       (write),
    .cpu_run     (cpu_run),
    .load_err    (load_err),
    .bytes_loaded(bytes_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Mode 0: A1, B2, C3, D4, E5 ...   Mode 1: byte value equals its index.
  function automatic logic [7:0] pay(input int mode, input int i);
    if (mode == 0) return 8'hA1 + 8'(i * 17);
    return 8'(i);
  endfunction

  // Monitor: every write strobe must match the next expected (addr,data) pair.
  always @(negedge clk) begin
    if (reset === 1'b1 && write === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write (t=%0t)",
                 Mem_ADDR, Mem_IN, $time);
      end else begin
        check("mem_write", {16'h0, Mem_ADDR, Mem_IN}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready_wait", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic load_stream(input logic [7:0] len, input int n, input int mode,
                             input logic [7:0] ck, input int gap_max, input bit req_mid);
    int g;
    send(len);
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) begin
        in_valid = 1'b0;
        g = $urandom_range(gap_max, 0);
        repeat (g) begin @(posedge clk); #1; end
      end
      load_req = req_mid && (i == 1);
      exp_q.push_back({BASE + 8'(i), pay(mode, i)});
      send(pay(mode, i));
      load_req = 1'b0;
    end
    check("cpu_held_before_chk", {31'h0, cpu_run}, 32'h0);
    send(ck);
    in_valid = 1'b0;
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    check("req_cpu_run", {31'h0, cpu_run}, 32'h0);
    check("req_load_err", {31'h0, load_err}, 32'h0);
    check("req_in_ready", {31'h0, in_ready}, 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'h0, in_ready}, 32'h0);
    check({tag, "_write"}, {31'h0, write}, 32'h0);
    check({tag, "_mem_in"}, {24'h0, Mem_IN}, 32'h0);
    check({tag, "_mem_addr"}, {24'h0, Mem_ADDR}, {24'h0, BASE});
    check({tag, "_cpu_run"}, {31'h0, cpu_run}, 32'h0);
    check({tag, "_load_err"}, {31'h0, load_err}, 32'h0);
    check({tag, "_bytes"}, {23'h0, bytes_loaded}, 32'h0);
  endtask

  task automatic check_run(input string tag, input int nbytes);
    check({tag, "_cpu_run"}, {31'h0, cpu_run}, 32'h1);
    check({tag, "_in_ready"}, {31'h0, in_ready}, 32'h0);
    check({tag, "_load_err"}, {31'h0, load_err}, 32'h0);
    check({tag, "_bytes"}, {23'h0, bytes_loaded}, 32'(nbytes));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    load_req = 1'b0;
    #22;
    check_reset_outputs("por");
    #1 reset = 1'b1;
    #1 check("ready_before_clock", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    check("ready_after_clock", {31'h0, in_ready}, 32'h1);

    // Basic: 03^A1^B2^C3 = D3.
    load_stream(8'h03, 3, 0, 8'hD3, 0, 1'b0);
    check_run("basic", 3);
    // in_valid while running must not be accepted.
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    check("run_ignores_valid", {23'h0, bytes_loaded}, 32'd3);

    // Reload from RUN, with an ignored load_req mid-payload: 02^A1^B2 = 11.
    pulse_load_req();
    load_stream(8'h02, 2, 0, 8'h11, 0, 1'b1);
    check_run("reload", 2);

    // Bad checksum.
    pulse_load_req();
    load_stream(8'h03, 3, 0, 8'h00, 0, 1'b0);
    check("bad_load_err", {31'h0, load_err}, 32'h1);
    check("bad_cpu_run", {31'h0, cpu_run}, 32'h0);
    check("bad_in_ready", {31'h0, in_ready}, 32'h0);
    repeat (2) begin @(posedge clk); #1; end
    check("bad_err_sticky", {31'h0, load_err}, 32'h1);
    pulse_load_req();

    // Stalled payload: 05^A1^B2^C3^D4^E5 = E4.
    load_stream(8'h05, 5, 0, 8'hE4, 3, 1'b0);
    check_run("stall", 5);
    pulse_load_req();

    // Asynchronous reset between edges after two of five payload bytes.
    send(8'h05);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({BASE + 8'(i), pay(0, i)});
      send(pay(0, i));
    end
    in_valid = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    load_stream(8'h05, 5, 0, 8'hE4, 0, 1'b0);
    check_run("after_reset", 5);
    pulse_load_req();

    // Full page from 0x80, wrapping; XOR of 0..255 with length 00 is 00.
    load_stream(8'h00, 256, 1, 8'h00, 0, 1'b0);
    check_run("full_page", 256);

    repeat (3) begin @(posedge clk); #1; end
    check("pending_writes", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
